// File: rtl/uart_pkg.sv
// Shared widths and encodings for the UART transmit path.
// The transmitter and its FIFO both take their sizes from here so the two
// instantiations always agree on data width and depth.
package uart_pkg;

  localparam int UART_DATA_W      = 8;
  localparam int UART_FIFO_ADDR_W = 4;
  localparam int UART_FIFO_AFULL  = 12;

  // Transmitter state encoding. It lives here so that the transmitter and
  // anything that monitors it agree on the width and the values.
  localparam int UART_TX_STATE_W = 3;

  typedef enum logic [UART_TX_STATE_W-1:0] {
    UART_TX_IDLE   = 3'd0,
    UART_TX_START  = 3'd1,
    UART_TX_DATA   = 3'd2,
    UART_TX_PARITY = 3'd3,
    UART_TX_STOP   = 3'd4
  } uart_tx_state_e;

  // Number of entries addressed by an addr_w-bit pointer.
  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM: one write port, one registered read port with read
// enable. No reset on the array or the read register so it maps onto
// block/distributed RAM. A read and write to the same address in one cycle
// returns the old contents (read-before-write).
module fifo_dpram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Write port and registered read port; the read register holds when re is low.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the RS-232 transmitter. Host writes on the wr side; the
// transmitter pops with rd_en and sees the word on dout one cycle later.
// All status outputs are registered and reflect the state after the edge.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W    = UART_DATA_W,
  parameter int ADDR_W    = UART_FIFO_ADDR_W,
  parameter int AFULL_LVL = UART_FIFO_AFULL
) (
  input  logic              clk_50mhz,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              almost_full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AFULL_CMP = PTR_W'(AFULL_LVL);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] level_q, level_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             afull_q, afull_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  // Set by the first accepted read after reset; until then dout reads as
  // zero because the RAM read register itself has no reset.
  logic             dout_vld_q, dout_vld_d;

  logic             wr_acc;
  logic             rd_acc;
  logic             ram_we;
  logic             ram_re;
  logic [DATA_W-1:0] ram_rdata;

  // Accept decisions. A write while full is still accepted when a read
  // frees the slot on the same edge.
  always_comb begin
    rd_acc = rd_en & ~empty_q;
    wr_acc = wr_en & (~full_q | rd_acc);
  end

  // Next pointers, level, flags and sticky errors; clr overrides both ports.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    dout_vld_d = dout_vld_q;
    empty_d    = empty_q;
    full_d     = full_q;
    afull_d    = afull_q;

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      empty_d  = 1'b1;
      full_d   = 1'b0;
      afull_d  = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        dout_vld_d = 1'b1;
      end

      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + PTR_W'(1);
        2'b01:   level_d = level_q - PTR_W'(1);
        default: level_d = level_q;
      endcase

      ovf_d = ovf_q | (wr_en & ~wr_acc);
      unf_d = unf_q | (rd_en & empty_q);

      empty_d = (wr_ptr_d == rd_ptr_d);
      full_d  = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
                (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
      afull_d = (level_d >= AFULL_CMP);
    end
  end

  // State registers; reset returns the FIFO to empty and discards contents.
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      dout_vld_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      afull_q    <= afull_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  // RAM port controls; a flush cycle neither stores nor updates dout.
  always_comb begin
    ram_we = wr_acc & ~clr;
    ram_re = rd_acc & ~clr;
  end

  fifo_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk_50mhz),
    .we    (ram_we),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (wr_data),
    .re    (ram_re),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  assign dout        = dout_vld_q ? ram_rdata : '0;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign level       = level_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a vector table for the short single-step
// cases plus hand-written sequences for fill/drain, wrap, flush and reset.
module tb_uart_tx_fifo;

  logic       clk_50mhz = 1'b0;
  logic       rst;
  logic       clr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic       full;
  logic       almost_full;
  logic [7:0] dout;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  always #10 clk_50mhz = ~clk_50mhz;

  uart_tx_fifo dut (
    .clk_50mhz   (clk_50mhz),
    .rst         (rst),
    .clr         (clr),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .almost_full (almost_full),
    .rd_en       (rd_en),
    .dout        (dout),
    .empty       (empty),
    .level       (level),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  typedef struct {
    logic       clr;
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic [4:0] lvl;
    logic       e;
    logic       f;
    logic       af;
    logic [7:0] dout;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t tbl [14];
  logic [7:0] model_q [$];

  function automatic vec_t mk(logic c, logic w, logic [7:0] d, logic r,
                              logic [4:0] l, logic e, logic f, logic af,
                              logic [7:0] o, logic ov, logic un);
    vec_t v;
    v.clr = c; v.wr = w; v.wd = d; v.rd = r;
    v.lvl = l; v.e = e; v.f = f; v.af = af; v.dout = o; v.ovf = ov; v.unf = un;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [4:0] l, input logic e,
                           input logic f, input logic af, input logic [7:0] o,
                           input logic ov, input logic un);
    chk({tag, ".level"}, int'(level), int'(l));
    chk({tag, ".empty"}, int'(empty), int'(e));
    chk({tag, ".full"}, int'(full), int'(f));
    chk({tag, ".almost_full"}, int'(almost_full), int'(af));
    chk({tag, ".dout"}, int'(dout), int'(o));
    chk({tag, ".overflow"}, int'(overflow), int'(ov));
    chk({tag, ".underflow"}, int'(underflow), int'(un));
  endtask

  task automatic cyc();
    @(posedge clk_50mhz);
    #1;
  endtask

  // Drive one cycle of inputs, let the edge take them, then release.
  task automatic step(input logic c, input logic w, input logic [7:0] d, input logic r);
    clr = c; wr_en = w; wr_data = d; rd_en = r;
    cyc();
    clr = 1'b0; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;

    // Reset, three writes/three reads, write+read while empty, flush.
    tbl[0]  = mk(0, 0, 8'h00, 0, 5'd0, 1, 0, 0, 8'h00, 0, 0);
    tbl[1]  = mk(0, 1, 8'h41, 0, 5'd1, 0, 0, 0, 8'h00, 0, 0);
    tbl[2]  = mk(0, 1, 8'h42, 0, 5'd2, 0, 0, 0, 8'h00, 0, 0);
    tbl[3]  = mk(0, 1, 8'h43, 0, 5'd3, 0, 0, 0, 8'h00, 0, 0);
    tbl[4]  = mk(0, 0, 8'h00, 1, 5'd2, 0, 0, 0, 8'h41, 0, 0);
    tbl[5]  = mk(0, 0, 8'h00, 1, 5'd1, 0, 0, 0, 8'h42, 0, 0);
    tbl[6]  = mk(0, 0, 8'h00, 1, 5'd0, 1, 0, 0, 8'h43, 0, 0);
    tbl[7]  = mk(0, 1, 8'h5A, 1, 5'd1, 0, 0, 0, 8'h43, 0, 1);
    tbl[8]  = mk(0, 0, 8'h00, 0, 5'd1, 0, 0, 0, 8'h43, 0, 1);
    tbl[9]  = mk(0, 0, 8'h00, 1, 5'd0, 1, 0, 0, 8'h5A, 0, 1);
    tbl[10] = mk(1, 0, 8'h00, 0, 5'd0, 1, 0, 0, 8'h5A, 0, 0);
    tbl[11] = mk(0, 1, 8'h77, 0, 5'd1, 0, 0, 0, 8'h5A, 0, 0);
    tbl[12] = mk(0, 1, 8'h78, 1, 5'd1, 0, 0, 0, 8'h77, 0, 0);
    tbl[13] = mk(0, 0, 8'h00, 1, 5'd0, 1, 0, 0, 8'h78, 0, 0);

    cyc();
    check_all("in_reset", 5'd0, 1, 0, 0, 8'h00, 0, 0);
    cyc();
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].clr, tbl[i].wr, tbl[i].wd, tbl[i].rd);
      check_all($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].e, tbl[i].f,
                tbl[i].af, tbl[i].dout, tbl[i].ovf, tbl[i].unf);
    end

    // Fill to full, overflow, then drain in order.
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 8'(i), 0);
      chk($sformatf("fill%0d.level", i), int'(level), i + 1);
      chk($sformatf("fill%0d.afull", i), int'(almost_full), (i + 1 >= 12) ? 1 : 0);
      chk($sformatf("fill%0d.full", i), int'(full), (i == 15) ? 1 : 0);
    end
    step(0, 1, 8'hFF, 0);
    check_all("ovf_write", 5'd16, 0, 1, 1, 8'h78, 1, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 8'h00, 1);
      chk($sformatf("drain%0d.dout", i), int'(dout), i);
      chk($sformatf("drain%0d.level", i), int'(level), 15 - i);
      chk($sformatf("drain%0d.empty", i), int'(empty), (i == 15) ? 1 : 0);
    end
    check_all("drained", 5'd0, 1, 0, 0, 8'h0F, 1, 0);

    // Flush with level 5 and overflow set; the concurrent write is dropped.
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 8'(8'h20 + i), 0);
    step(0, 1, 8'hEE, 0);
    for (int i = 0; i < 11; i++) step(0, 0, 8'h00, 1);
    check_all("pre_clr", 5'd5, 0, 0, 0, 8'h2A, 1, 0);
    step(1, 1, 8'h99, 0);
    check_all("clr_wr", 5'd0, 1, 0, 0, 8'h2A, 0, 0);
    step(0, 0, 8'h00, 1);
    check_all("after_clr_rd", 5'd0, 1, 0, 0, 8'h2A, 0, 1);

    // Read+write while full for 40 cycles across pointer wrap.
    step(1, 0, 8'h00, 0);
    model_q.delete();
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 8'(8'h10 + i), 0);
      model_q.push_back(8'(8'h10 + i));
    end
    for (int j = 0; j < 40; j++) begin
      logic [7:0] wd;
      logic [7:0] exp_d;
      wd = (j == 0) ? 8'hA5 : 8'(8'h60 + j);
      step(0, 1, wd, 1);
      exp_d = model_q.pop_front();
      model_q.push_back(wd);
      chk($sformatf("rw_full%0d.dout", j), int'(dout), int'(exp_d));
      chk($sformatf("rw_full%0d.level", j), int'(level), 16);
      chk($sformatf("rw_full%0d.full", j), int'(full), 1);
      chk($sformatf("rw_full%0d.overflow", j), int'(overflow), 0);
    end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp_d;
      step(0, 0, 8'h00, 1);
      exp_d = model_q.pop_front();
      chk($sformatf("wrap_drain%0d.dout", i), int'(dout), int'(exp_d));
    end
    check_all("wrap_done", 5'd0, 1, 0, 0, 8'h87, 0, 0);

    // Asynchronous reset in the middle of a burst.
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h11, 0);
    step(0, 1, 8'h22, 0);
    step(0, 1, 8'h33, 1);
    check_all("pre_rst", 5'd2, 0, 0, 0, 8'h11, 0, 0);
    wr_en = 1'b1; wr_data = 8'h44; rd_en = 1'b0;
    @(posedge clk_50mhz);
    #5;
    rst = 1'b1;
    #1;
    check_all("async_rst", 5'd0, 1, 0, 0, 8'h00, 0, 0);
    wr_en = 1'b0; wr_data = 8'h00;
    cyc();
    rst = 1'b0;
    step(0, 0, 8'h00, 1);
    check_all("post_rst_rd", 5'd0, 1, 0, 0, 8'h00, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
